ultrasonic_dist_proc: RTL and testbench



---
 rtl/ultrasonic_dist_proc_pkg.sv | 34 +++
 rtl/ultrasonic_dist_proc_bin2bcd_seq.sv | 56 +++++
 rtl/ultrasonic_dist_proc.sv | 161 ++++++++++++++++
 tb/tb_ultrasonic_dist_proc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_dist_proc_pkg.sv
// ultrasonic_dist_proc_pkg
//   Shared definitions for the ultrasonic distance post-processing slice.
//   These are the distance/BCD widths used by the upstream range stage, the
//   default accepted range, the FSM state encodings, and the double-dabble step.
//   This file has no ports. It is imported by ultrasonic_dist_proc and its
//   bin2bcd_seq engine.
package ultrasonic_dist_proc_pkg;

    localparam int DIST_W     = 9;              // distance sample width (cm)
    localparam int BCD_W      = 12;             // three BCD digits
    localparam int SUM_W      = 11;             // 4 * 400 = 1600 < 2048
    localparam int DD_W       = BCD_W + DIST_W; // double-dabble working register
    localparam int DEF_MAX_CM = 400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // This is one double-dabble iteration. Each BCD digit that is >= 5 gets 3
    // added to it, and then the whole register shifts left by one bit.
    function automatic logic [DD_W-1:0] dabble_step(input logic [DD_W-1:0] s);
        logic [DD_W-1:0] t;
        t = s;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (t[DIST_W + 4*i +: 4] >= 4'd5)
                t[DIST_W + 4*i +: 4] = t[DIST_W + 4*i +: 4] + 4'd3;
        end
        return {t[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/ultrasonic_dist_proc_bin2bcd_seq.sv
// ultrasonic_dist_proc_bin2bcd_seq  (the bin2bcd_seq engine)
//   This is a sequential double-dabble converter. It takes a 9-bit binary value
//   and produces 3 BCD digits. It runs one iteration per clock, for 9 iterations.
//   It owns the iteration counter, and the caller waits for its done strobe.
//   Ports:
//     clk      in   system clock
//     reset_p  in   synchronous active-high reset
//     start    in   1 = load bin and begin converting (one cycle)
//     bin      in   9-bit binary value
//     bcd      out  12-bit BCD result, valid while done is high and held after
//     done     out  one-cycle strobe on the cycle the result becomes final
module ultrasonic_dist_proc_bin2bcd_seq
    import ultrasonic_dist_proc_pkg::*;
(
    input  logic              clk,
    input  logic              reset_p,
    input  logic              start,
    input  logic [DIST_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              done
);

    logic [DD_W-1:0] shift_reg;
    logic [3:0]      iter_cnt;
    logic            active;

    // NOTE: state registers update with non-blocking (<=) assignments so that
    // every flop samples the values from before the edge. Blocking assignments
    // here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            shift_reg <= '0;
            iter_cnt  <= '0;
            active    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shift_reg <= {{BCD_W{1'b0}}, bin};
                iter_cnt  <= '0;
                active    <= 1'b1;
            end else if (active) begin
                shift_reg <= dabble_step(shift_reg);
                if (iter_cnt == 4'(DIST_W - 1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    iter_cnt <= iter_cnt + 4'd1;
                end
            end
        end
    end

    assign bcd = shift_reg[DD_W-1:DIST_W];

endmodule

// File: rtl/ultrasonic_dist_proc.sv
// ultrasonic_dist_proc
//   This block qualifies distance samples in cm and keeps a 4-sample moving
//   average. It converts the average to 3-digit BCD for the display, and it
//   drives a proximity alarm with hysteresis.
//   Ports:
//     clk           in   system clock
//     reset_p       in   synchronous active-high reset
//     dis_valid     in   one-cycle strobe qualifying dis_time
//     dis_time      in   measured distance in cm (9 bits)
//     avg_cm        out  current 4-sample average, truncated (9 bits)
//     bcd           out  avg_cm as BCD: [11:8] hundreds, [7:4] tens, [3:0] units
//     bcd_valid     out  one-cycle pulse when bcd updates
//     busy          out  conversion in progress
//     near          out  proximity alarm
//     out_of_range  out  last sample was rejected
module ultrasonic_dist_proc
    import ultrasonic_dist_proc_pkg::*;
#(
    parameter int NEAR_CM = 20,
    parameter int HYST_CM = 5,
    parameter int MAX_CM  = DEF_MAX_CM
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              dis_valid,
    input  logic [DIST_W-1:0] dis_time,
    output logic [DIST_W-1:0] avg_cm,
    output logic [BCD_W-1:0]  bcd,
    output logic              bcd_valid,
    output logic              busy,
    output logic              near,
    output logic              out_of_range
);

    localparam logic [DIST_W-1:0] MAX_T     = DIST_W'(MAX_CM);
    localparam logic [DIST_W:0]   NEAR_SET  = (DIST_W+1)'(NEAR_CM);
    localparam logic [DIST_W:0]   NEAR_CLR  = (DIST_W+1)'(NEAR_CM + HYST_CM);

    logic              accept;
    logic [DIST_W-1:0] buf_mem [4];
    logic [1:0]        wr_ptr;
    logic [SUM_W-1:0]  sum;
    logic              filled;
    state_t            state;
    logic              pending;
    logic              avg_upd;
    logic              conv_start;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;

    assign accept = dis_valid && (dis_time != '0) && (dis_time <= MAX_T);

    // ---------------- Averager ----------------
    // NOTE: the sample buffer has no reset. The filled flag marks it as empty.
    // The first accepted sample overwrites every entry, so stale contents are
    // never read.
    always_ff @(posedge clk) begin
        if (!reset_p && accept) begin
            if (!filled) begin
                for (int i = 0; i < 4; i++) buf_mem[i] <= dis_time;
            end else begin
                buf_mem[wr_ptr] <= dis_time;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            sum    <= '0;
            wr_ptr <= '0;
            filled <= 1'b0;
        end else if (accept) begin
            if (!filled) begin
                // Preload: the window starts full of this sample, so there is no ramp-up.
                sum    <= {dis_time, 2'b00};
                filled <= 1'b1;
            end else begin
                // The sum is always >= the oldest entry, so this cannot underflow.
                sum    <= sum + SUM_W'(dis_time) - SUM_W'(buf_mem[wr_ptr]);
                wr_ptr <= wr_ptr + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p)        out_of_range <= 1'b0;
        else if (dis_valid) out_of_range <= !accept;
    end

    // ---------------- Conversion control FSM ----------------
    // The engine loads on the same edge that LOAD captures avg_cm. Both take
    // sum[10:2], so the value converted is exactly the value shown.
    assign conv_start = (state == ST_LOAD);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state     <= ST_IDLE;
            avg_cm    <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
            pending   <= 1'b0;
            avg_upd   <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            avg_upd   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    avg_cm  <= sum[SUM_W-1:2];
                    busy    <= 1'b1;
                    avg_upd <= 1'b1;
                    state   <= ST_CONV;
                    // If a sample lands on this edge, it is missing from the sum being captured.
                    if (accept) pending <= 1'b1;
                end
                ST_CONV: begin
                    if (accept) pending <= 1'b1;
                    if (conv_done) begin
                        bcd       <= conv_bcd;
                        bcd_valid <= 1'b1;
                        busy      <= pending || accept;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A sample on this edge is already in the sum that the next LOAD captures.
                    if (pending || accept) begin
                        pending <= 1'b0;
                        state   <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- Near alarm with hysteresis ----------------
    always_ff @(posedge clk) begin
        if (reset_p) begin
            near <= 1'b0;
        end else if (avg_upd) begin
            if ({1'b0, avg_cm} < NEAR_SET)       near <= 1'b1;
            else if ({1'b0, avg_cm} >= NEAR_CLR) near <= 1'b0;
        end
    end

    ultrasonic_dist_proc_bin2bcd_seq u_bin2bcd_seq (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (conv_start),
        .bin     (sum[SUM_W-1:2]),
        .bcd     (conv_bcd),
        .done    (conv_done)
    );

endmodule

// File: tb/tb_ultrasonic_dist_proc.sv
// tb_ultrasonic_dist_proc
//   This is the directed-vector bench for ultrasonic_dist_proc. Each expected
//   conversion is queued when its sample is driven. A monitor pops the queue on
//   every bcd_valid pulse and compares against it.
module tb_ultrasonic_dist_proc;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        dis_valid;
    logic [8:0]  dis_time;
    logic [8:0]  avg_cm;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic        near;
    logic        out_of_range;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [11:0] bcd;
        logic [8:0]  avg;
        int          cyc;   // expected bcd_valid edge, -1 = order only
    } exp_t;
    exp_t sb[$];

    ultrasonic_dist_proc dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .dis_valid    (dis_valid),
        .dis_time     (dis_time),
        .avg_cm       (avg_cm),
        .bcd          (bcd),
        .bcd_valid    (bcd_valid),
        .busy         (busy),
        .near         (near),
        .out_of_range (out_of_range)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: on every bcd_valid pulse, pop and compare one expected conversion.
    initial begin
        forever begin
            @(negedge clk);
            if (bcd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bcd_valid: got bcd 0x%0h expected no pulse (cycle %0d)", bcd, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("bcd_value", 32'(bcd), 32'(e.bcd));
                    check("bcd_avg", 32'(avg_cm), 32'(e.avg));
                    if (e.cyc >= 0) check("bcd_latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Call this at a negedge. It drives one sample so that it is taken at the
    // next posedge (edge k), then returns at the negedge just after edge k.
    task automatic send(input logic [8:0] d, input bit push, input logic [8:0] want_avg,
                        input logic [11:0] want_bcd, input bit timed);
        exp_t e;
        if (push) begin
            e.bcd = want_bcd;
            e.avg = want_avg;
            e.cyc = timed ? cyc + 1 + 11 : -1;
            sb.push_back(e);
        end
        dis_valid = 1'b1;
        dis_time  = d;
        @(negedge clk);
        dis_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending conversions expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_avg"},   32'(avg_cm), 0);
        check({tag, "_bcd"},   32'(bcd), 0);
        check({tag, "_valid"}, 32'(bcd_valid), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_near"},  32'(near), 0);
        check({tag, "_oor"},   32'(out_of_range), 0);
    endtask

    // Send one sample, then check avg_cm/busy at k+1 and near at k+2.
    task automatic send_chk(input logic [8:0] d, input logic [8:0] want_avg,
                            input logic [11:0] want_bcd, input bit want_near);
        send(d, 1'b1, want_avg, want_bcd, 1'b1);
        @(negedge clk);
        check("avg_k1", 32'(avg_cm), 32'(want_avg));
        check("busy_k1", 32'(busy), 1);
        @(negedge clk);
        check("near_k2", 32'(near), 32'(want_near));
        wait_idle();
    endtask

    initial begin
        int drops;
        reset_p   = 1'b1;
        dis_valid = 1'b0;
        dis_time  = '0;
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        check_all_zero("reset");

        // First sample preloads the window.
        send_chk(9'd100, 9'd100, 12'h100, 1'b0);

        // 100,100,100,20 -> sum 320, avg 80.
        send_chk(9'd100, 9'd100, 12'h100, 1'b0);
        send_chk(9'd100, 9'd100, 12'h100, 1'b0);
        send_chk(9'd20,  9'd80,  12'h080, 1'b0);

        // Rejections: 0 and 450 leave everything else alone.
        send(9'd0, 1'b0, '0, '0, 1'b0);
        check("oor_zero", 32'(out_of_range), 1);
        check("oor_zero_avg", 32'(avg_cm), 80);
        check("oor_zero_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        send(9'd450, 1'b0, '0, '0, 1'b0);
        check("oor_450", 32'(out_of_range), 1);
        repeat (15) @(negedge clk);
        check("oor_450_avg", 32'(avg_cm), 80);
        check("oor_450_bcd", 32'(bcd), 32'h080);
        // Window 100,100,100,20 plus 50 drops a 100: (320+50-100)/4 = 67.
        send(9'd50, 1'b1, 9'd67, 12'h067, 1'b1);
        check("oor_cleared", 32'(out_of_range), 0);
        wait_idle();

        // Hysteresis: 10 sets near. Then 15 and 20 hold it, and 25 clears it.
        do_reset();
        send_chk(9'd10, 9'd10, 12'h010, 1'b1);
        send_chk(9'd30, 9'd15, 12'h015, 1'b1);
        send_chk(9'd30, 9'd20, 12'h020, 1'b1);
        send_chk(9'd30, 9'd25, 12'h025, 1'b0);

        // A sample during CONV is queued, and busy stays high through both conversions.
        do_reset();
        send(9'd100, 1'b1, 9'd100, 12'h100, 1'b1);   // edge k
        @(negedge clk);                                // k+1
        check("chain_busy_k1", 32'(busy), 1);
        @(negedge clk);                                // k+2
        send(9'd40, 1'b1, 9'd85, 12'h085, 1'b0);     // edge k+3
        drops = 0;
        for (int i = 0; i < 17; i++) begin
            if (busy !== 1'b1) drops++;
            @(negedge clk);
        end
        check("busy_chained", 32'(drops), 0);
        wait_idle();

        // Reset at k+5 aborts the conversion, and the next sample preloads again.
        send(9'd100, 1'b0, '0, '0, 1'b0);            // edge k
        repeat (4) @(negedge clk);                     // k+4
        reset_p = 1'b1;
        @(negedge clk);                                // edge k+5 sampled reset
        reset_p = 1'b0;
        check_all_zero("abort");
        repeat (15) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 0);
        send_chk(9'd60, 9'd60, 12'h060, 1'b0);

        wait_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: if the run stalls, stop it outright.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
